// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: key edge strobes, operand A/B selection, signs, multiplier start and display select.
// Optional inactivity timeout is compiled in with `define ENTRY_TIMEOUT_EN.
module keypad_entry_ctrl #(
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_value,
    input  logic       key_pressed,
    input  logic       mult_done,
    output logic       key_strobe,
    output logic [3:0] key_digit,
    output logic [2:0] is_sign_key,
    output logic       enable_A,
    output logic       enable_B,
    output logic       clear_all,
    output logic       start_mult,
    output logic       sign_A,
    output logic       sign_B,
    output logic [1:0] display_sel,
    output logic       digit_err,
    output logic       busy
);
    typedef enum logic [2:0] {S_IDLE, S_ENTER_A, S_ENTER_B, S_START, S_WAIT, S_SHOW} state_t;

    localparam int            CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
    localparam logic [3:0]    K_A = 4'hA, K_B = 4'hB, K_C = 4'hC, K_E = 4'hE;

    state_t        state_q, state_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_q, strobe_d, clr_q, clr_d, start_q, start_d;
    logic [3:0]    digit_q, digit_d;
    logic [2:0]    code_q, code_d;
    logic          enA_q, enA_d, enB_q, enB_d, sA_q, sA_d, sB_q, sB_d;
    logic          err_q, err_d, busy_q, busy_d;
    logic [1:0]    disp_q, disp_d;
    logic          ev, in_entry, timeout, do_clear;

    assign ev       = key_pressed & ~prev_q;
    assign in_entry = (state_q == S_ENTER_A) || (state_q == S_ENTER_B);
    assign do_clear = (state_q == S_IDLE) || timeout ||
                      (ev && ((in_entry && key_value == K_C) || state_q == S_SHOW));

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q;
    logic          timed;

    assign timed   = in_entry || (state_q == S_SHOW);
    assign timeout = timed && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !timed || ev || state_d != state_q || timeout)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    // State and registered-output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            clr_q    <= 1'b0;
            start_q  <= 1'b0;
            digit_q  <= '0;
            code_q   <= '0;
            enA_q    <= 1'b0;
            enB_q    <= 1'b0;
            sA_q     <= 1'b0;
            sB_q     <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            disp_q   <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= key_pressed;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            clr_q    <= clr_d;
            start_q  <= start_d;
            digit_q  <= digit_d;
            code_q   <= code_d;
            enA_q    <= enA_d;
            enB_q    <= enB_d;
            sA_q     <= sA_d;
            sB_q     <= sB_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            disp_q   <= disp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    state_d = S_ENTER_A;
            S_ENTER_A: if (ev && key_value == K_A && cnt_q != '0) state_d = S_ENTER_B;
            S_ENTER_B: if (ev && key_value == K_E && cnt_q != '0) state_d = S_START;
            S_START:   state_d = S_WAIT;
            S_WAIT:    if (mult_done) state_d = S_SHOW;
            S_SHOW:    state_d = state_q;
            default:   state_d = S_IDLE;
        endcase
        if (do_clear) state_d = S_ENTER_A;
    end

    // Enables/display/busy decode the state the current event was taken in,
    // so a commit strobe still arrives alongside the operand it commits.
    always_comb begin
        strobe_d = 1'b0;
        clr_d    = 1'b0;
        code_d   = 3'b000;
        digit_d  = digit_q;
        cnt_d    = cnt_q;
        sA_d     = sA_q;
        sB_d     = sB_q;
        err_d    = err_q;
        start_d  = (state_q == S_START);
        enA_d    = (state_q == S_ENTER_A);
        enB_d    = (state_q == S_ENTER_B);
        busy_d   = (state_q == S_START) || (state_q == S_WAIT);
        disp_d   = (state_q == S_SHOW)    ? 2'b10 :
                   (state_q == S_ENTER_A) ? 2'b00 :
                   (state_q == S_IDLE)    ? 2'b00 : 2'b01;
        if (do_clear) begin
            clr_d = 1'b0 | 1'b1;
            sA_d  = 1'b0;
            sB_d  = 1'b0;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (ev && in_entry) begin
            if (key_value <= 4'd9) begin
                if (cnt_q < MAX_CNT) begin
                    strobe_d = 1'b1;
                    digit_d  = key_value;
                    cnt_d    = cnt_q + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (key_value == K_B) begin
                strobe_d = 1'b1;
                digit_d  = key_value;
                if (state_q == S_ENTER_A) begin
                    sA_d   = ~sA_q;
                    code_d = sA_d ? 3'b100 : 3'b010;
                end else begin
                    sB_d   = ~sB_q;
                    code_d = sB_d ? 3'b100 : 3'b010;
                end
            end else if (cnt_q != '0 &&
                         ((state_q == S_ENTER_A && key_value == K_A) ||
                          (state_q == S_ENTER_B && key_value == K_E))) begin
                strobe_d = 1'b1;
                digit_d  = key_value;
                code_d   = 3'b001;
                cnt_d    = '0;
                err_d    = 1'b0;
            end
        end
    end

    assign key_strobe  = strobe_q;
    assign key_digit   = digit_q;
    assign is_sign_key = code_q;
    assign enable_A    = enA_q;
    assign enable_B    = enB_q;
    assign clear_all   = clr_q;
    assign start_mult  = start_q;
    assign sign_A      = sA_q;
    assign sign_B      = sB_q;
    assign display_sel = disp_q;
    assign digit_err   = err_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl; expected values are hand-derived constants.
module tb_keypad_entry_ctrl;
`ifdef ENTRY_TIMEOUT_EN
    localparam int TMO  = 16;
    localparam int HOLD = 12;
`else
    localparam int TMO  = 50_000_000;
    localparam int HOLD = 20;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] key_value = '0;
    logic       key_pressed = 1'b0, mult_done = 1'b0;
    logic       key_strobe, enable_A, enable_B, clear_all, start_mult;
    logic       sign_A, sign_B, digit_err, busy;
    logic [3:0] key_digit;
    logic [2:0] is_sign_key;
    logic [1:0] display_sel;

    int n_assert = 0, n_fail = 0;

    // Outputs sampled after the event edge (s_*) and after the release edge (r_*)
    logic [3:0] s_digit;
    logic [2:0] s_code;
    logic       s_strobe, s_enA, s_enB, s_clr, s_err, s_sA, s_sB;
    logic       r_strobe, r_start, r_enA, r_enB, r_busy;

    keypad_entry_ctrl #(.MAX_DIGITS(3), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(key_pressed),
        .mult_done(mult_done), .key_strobe(key_strobe), .key_digit(key_digit),
        .is_sign_key(is_sign_key), .enable_A(enable_A), .enable_B(enable_B),
        .clear_all(clear_all), .start_mult(start_mult), .sign_A(sign_A), .sign_B(sign_B),
        .display_sel(display_sel), .digit_err(digit_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_value   = k;
        key_pressed = 1'b1;
        tick();
        s_strobe = key_strobe; s_code = is_sign_key; s_digit = key_digit;
        s_enA = enable_A; s_enB = enable_B; s_clr = clear_all; s_err = digit_err;
        s_sA = sign_A; s_sB = sign_B;
        key_pressed = 1'b0;
        tick();
        r_strobe = key_strobe; r_start = start_mult; r_enA = enable_A;
        r_enB = enable_B; r_busy = busy;
    endtask

    initial begin
        int nstb, nbusy, ncyc;
        logic [3:0] hdig;

        // Reset
        tick(); tick();
        chk("reset_outputs", {key_strobe, key_digit, is_sign_key, enable_A, enable_B, clear_all,
                              start_mult, sign_A, sign_B, display_sel, digit_err, busy}, 0);
        rst = 1'b0;
        tick();
        chk("idle_clear_all", clear_all, 1);
        tick();
        chk("clear_all_pulse_end", clear_all, 0);
        chk("enter_A_enable", {enable_A, enable_B}, 2'b10);

        // Test 1: 1,2,A,3,E then mult_done
        press(4'd1);
        chk("t1_d1", {s_strobe, s_code, s_digit, s_enA, s_enB}, {1'b1, 3'b000, 4'd1, 2'b10});
        chk("t1_d1_onecycle", r_strobe, 0);
        press(4'd2);
        chk("t1_d2", {s_strobe, s_code, s_digit, s_enA, s_enB}, {1'b1, 3'b000, 4'd2, 2'b10});
        press(4'hA);
        chk("t1_commitA", {s_strobe, s_code, s_enA, s_enB}, {1'b1, 3'b001, 2'b10});
        chk("t1_enB_after", {r_enA, r_enB}, 2'b01);
        press(4'd3);
        chk("t1_d3", {s_strobe, s_code, s_digit, s_enA, s_enB}, {1'b1, 3'b000, 4'd3, 2'b01});
        press(4'hE);
        chk("t1_commitE", {s_strobe, s_code, s_enA, s_enB}, {1'b1, 3'b001, 2'b01});
        chk("t1_start_mult", {r_strobe, r_start, r_busy}, 3'b011);
        nbusy = 0; nstb = 0;
        repeat (3) begin
            tick();
            nbusy += int'(busy);
            nstb  += int'(start_mult);
        end
        chk("t1_busy_wait", nbusy, 3);
        chk("t1_start_single", nstb, 0);
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        tick();
        chk("t1_show", {busy, display_sel}, {1'b0, 2'b10});

        // Any key in S_SHOW clears and is consumed
        press(4'd7);
        chk("show_key_clear", {s_clr, s_strobe}, 2'b10);
        chk("show_to_A", {r_enA, r_enB}, 2'b10);

        // Test 2: held key gives one strobe
        key_value = 4'd5; key_pressed = 1'b1; nstb = 0; hdig = '0;
        repeat (HOLD) begin
            tick();
            if (key_strobe) begin nstb++; hdig = key_digit; end
        end
        key_pressed = 1'b0;
        tick();
        chk("t2_hold_count", nstb, 1);
        chk("t2_hold_digit", hdig, 4'd5);

        // Clear, then commit with no digits is ignored
        press(4'hC);
        chk("keyC_clear", {s_clr, s_strobe}, 2'b10);
        press(4'hA);
        chk("A_cnt0_ignored", {s_strobe, r_enA}, 2'b01);
        press(4'hD);
        chk("keyD_ignored", {s_strobe, s_clr}, 2'b00);

        // Test 3: digit limit, sign A, commit clears digit_err
        press(4'd9); chk("t3_9a", {s_strobe, s_code}, {1'b1, 3'b000});
        press(4'd9); chk("t3_9b", {s_strobe, s_code}, {1'b1, 3'b000});
        press(4'd9); chk("t3_9c", {s_strobe, s_code, s_err}, {1'b1, 3'b000, 1'b0});
        press(4'd9); chk("t3_9d_dropped", {s_strobe, s_err}, 2'b01);
        press(4'hB); chk("t3_signA", {s_strobe, s_code, s_sA, s_err}, {1'b1, 3'b100, 1'b1, 1'b1});
        press(4'hA); chk("t3_commit_err_clr", {s_strobe, s_code, s_err}, {1'b1, 3'b001, 1'b0});

        // Test 4: S_ENTER_B sign toggles, A and E with cnt=0 ignored
        press(4'hE); chk("E_cnt0_ignored", {s_strobe, r_busy, r_enB}, 3'b001);
        press(4'hB); chk("t4_signB_1", {s_strobe, s_code, s_sB, s_sA}, {1'b1, 3'b100, 1'b1, 1'b1});
        press(4'hB); chk("t4_signB_0", {s_strobe, s_code, s_sB, s_sA}, {1'b1, 3'b010, 1'b0, 1'b1});
        press(4'hA); chk("A_in_B_ignored", {s_strobe, r_enA, r_enB}, 3'b001);

        // Test 5: reset during S_WAIT
        press(4'd4);
        press(4'hE);
        chk("t5_start", r_start, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_reset_outputs", {key_strobe, key_digit, is_sign_key, enable_A, enable_B, clear_all,
                                 start_mult, sign_A, sign_B, display_sel, digit_err, busy}, 0);
        rst = 1'b0; mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        chk("t5_clear_after_reset", {clear_all, busy}, 2'b10);
        tick();
        chk("t5_enter_A", {enable_A, display_sel, busy, clear_all}, {1'b1, 2'b00, 1'b0, 1'b0});

`ifdef ENTRY_TIMEOUT_EN
        // Test 6: idle timeout in S_ENTER_B
        press(4'd1);
        press(4'hA);
        ncyc = 0;
        while (!clear_all && ncyc < 40) begin
            tick();
            ncyc++;
        end
        chk("t6_timeout_cycle", ncyc, TMO - 1);
        tick();
        chk("t6_enter_A", {enable_A, enable_B}, 2'b10);
`else
        ncyc = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
